mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle main control unit for the MIPS datapath: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back states. It is the driving end of the ALU interface. It issues the 3-bit ALU operation code and operand selects, and it consumes the ALU's zero and overflow flags to resolve branches and to suppress write-back on arithmetic overflow. It sits between the instruction register (IR) and the datapath muxes and enables.

## Interface
Parameters:
- `RESET_STATE`, default 3'd0 (`S_IF`): state entered on reset.

Ports:
- `clk` in 1: system clock; all state changes happen on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 6: IR[31:26], stable from ID onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag (A==B).
- `overflow` in 1: ALU signed-add overflow flag.
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: next-PC select. 00 = PC+4, 01 = branch target, 10 = jump target.
- `ir_we` out 1: IR load enable.
- `mem_we` out 1: data memory write enable.
- `reg_we` out 1: register file write enable.
- `reg_dst` out 2: write register select. 00 = rt, 01 = rd.
- `wb_sel` out 1: write-back data select. 0 = ALU result register, 1 = memory data register.
- `alu_srcb` out 1: ALU B operand select. 0 = rt, 1 = extended immediate.
- `ext_op` out 1: immediate extension. 1 = sign-extend, 0 = zero-extend.
- `alu_ctr` out 3: ALU operation code. 000 = slt, 001 = or, 010 = add, 011 = lui, 101 = sll, 110 = sub.
- `ov_trap` out 1: one-cycle pulse when write-back is suppressed by overflow.
- `illegal` out 1: one-cycle pulse when an unknown opcode or funct is decoded.
- `state` out 3: current state, for debug.

## Operation
- States: `S_IF`=0, `S_ID`=1, `S_EXE`=2, `S_MEM`=3, `S_WB`=4.
- Outputs are decoded from the state plus `op`/`funct`. All enables are 0 in any state not listed below.
- **S_IF**: `ir_we`=1, `pc_we`=1, `pc_src`=00. Next state: `S_ID`.
- **S_ID**:
  - j (000010): `pc_we`=1, `pc_src`=10; next state `S_IF`.
  - Illegal op or R-type funct: `illegal`=1; next state `S_IF`, treated as a nop.
  - Otherwise: next state `S_EXE`.
- **S_EXE**: `alu_ctr`, `alu_srcb` and `ext_op` are set per instruction:
  - addu (funct 100001): 010, rt.
  - subu (100011): 110, rt.
  - slt (101010): 000, rt.
  - sll (000000): 101, rt.
  - ori (op 001101): 001, imm, zero-extend.
  - lui (001111): 011, imm.
  - addi (001000): 010, imm, sign-extend.
  - lw (100011) / sw (101011): 010, imm, sign-extend.
  - beq (000100): 110, rt.
- **beq in S_EXE**: `pc_we`=`zero`, `pc_src`=01. Next state `S_IF`.
- **lw/sw**: `S_EXE` goes to `S_MEM`. For sw, `mem_we`=1 in `S_MEM`, then `S_IF`. For lw, `S_MEM` goes to `S_WB`.
- **All others**: `S_EXE` goes to `S_WB`.
- **Overflow capture**: `overflow` is registered at the end of `S_EXE` for addi only. The register is cleared on every `S_IF`.
- **S_WB**:
  - `reg_we`=1 unless the instruction is addi and the registered overflow is 1. In that case `reg_we`=0 and `ov_trap`=1.
  - `reg_dst`=01 for R-type, 00 otherwise.
  - `wb_sel`=1 for lw only.
  - Next state: `S_IF`.
- **Unknown state encodings** (5–7): go to `S_IF` with all enables 0.

## Timing
- CPI:
  - j and illegal: 2.
  - beq: 3.
  - R-type, ori, lui, addi, sw: 4.
  - lw: 5.
- **Reset**: `state`=`S_IF` immediately, with no clock required. While `rst`=1, every enable, `ov_trap` and `illegal` is forced to 0, and `alu_ctr`=000, `pc_src`=00, `reg_dst`=00. The first `ir_we` pulse occurs in the first cycle after `rst` falls.
- **Reset mid-instruction**: the state is abandoned with no partial write. Enables drop in the same cycle `rst` rises, and the overflow register is cleared.
- **Flag sampling**: `zero` and `overflow` are sampled only in `S_EXE`, which has the same-cycle combinational ALU path. Flag changes in other states have no effect.
- **Pulse width**: `ov_trap` and `illegal` are exactly one cycle wide.

## Test plan
- **Reset**: raise `rst` mid-cycle during `S_EXE`. Required: `state`=0 asynchronously and all enables 0. One cycle after release: `ir_we`=1 and `pc_we`=1.
- **addu**: `op`=000000, `funct`=100001. Required: states 0,1,2,4; `alu_ctr`=010 in EXE; in WB, `reg_we`=1 with `reg_dst`=01.
- **beq**: `op`=000100.
  - With `zero`=1: `pc_we`=1 and `pc_src`=01 in EXE, then IF.
  - With `zero`=0: `pc_we`=0 in EXE.
  - Both cases: 3-cycle CPI.
- **addi with overflow**: `op`=001000, `overflow`=1 in EXE. Required: WB has `reg_we`=0 and `ov_trap`=1 for exactly 1 cycle. Repeating with `overflow`=0 gives `reg_we`=1.
- **lw then sw**: lw gives states 0,1,2,3,4 with `wb_sel`=1 in WB. sw gives states 0,1,2,3 with `mem_we`=1 only in MEM. Both have `alu_ctr`=010 and `ext_op`=1.
- **Illegal, lui and j**: `op`=111111 gives `illegal`=1 in ID and a return to IF. lui gives `alu_ctr`=011. j gives `pc_src`=10 in ID with 2-cycle CPI.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller
//   Multi-cycle MIPS main control unit. A Moore FSM steps each instruction
//   through IF -> ID -> EXE -> (MEM) -> (WB). It drives the datapath enables
//   and mux selects, and it issues the 3-bit ALU code. It consumes the ALU
//   zero flag to resolve beq, and the overflow flag to suppress addi
//   write-back.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   op, funct       : IR[31:26] and IR[5:0]
//   zero, overflow  : ALU flags, only looked at in EXE
//   pc_we, pc_src   : PC write enable and next-PC select (00 +4, 01 branch, 10 jump)
//   ir_we, mem_we   : IR load and data memory write enables
//   reg_we, reg_dst : register file write enable and destination select (00 rt, 01 rd)
//   wb_sel          : write-back source (0 ALU result, 1 memory data)
//   alu_srcb, ext_op: ALU B select (1 = immediate) and sign(1)/zero(0) extension
//   alu_ctr         : ALU operation code
//   ov_trap, illegal: one-cycle pulses for suppressed write-back / bad decode
//   state           : current FSM state, for debug
module mc_controller #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic       wb_sel,
  output logic       alu_srcb,
  output logic       ext_op,
  output logic [2:0] alu_ctr,
  output logic       ov_trap,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_SLT  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  state_t cur_state;
  state_t nxt_state;
  logic   ov_reg;

  logic is_rtype, is_j, is_beq, is_addi, is_ori, is_lui, is_lw, is_sw;
  logic r_legal, legal;

  assign state = cur_state;

  // Instruction class decode from the IR fields.
  assign is_rtype = (op == OP_RTYPE);
  assign is_j     = (op == OP_J);
  assign is_beq   = (op == OP_BEQ);
  assign is_addi  = (op == OP_ADDI);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign r_legal  = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) ||
                                 (funct == FN_SLT)  || (funct == FN_SLL));
  assign legal    = r_legal || is_j || is_beq || is_addi || is_ori ||
                    is_lui || is_lw || is_sw;

  // State register; reset abandons whatever instruction was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= state_t'(RESET_STATE);
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Overflow is only meaningful at the end of an addi EXE cycle. It is
  // cleared at every fetch so that a stale flag never reaches a later WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_reg <= 1'b0;
    end else if (cur_state == S_IF) begin
      ov_reg <= 1'b0;
    end else if (cur_state == S_EXE && is_addi) begin
      ov_reg <= overflow;
    end
  end

  // Next-state and Moore-style output decode. Reset forces every output
  // low combinationally, so enables drop in the same cycle rst rises.
  always_comb begin
    nxt_state = S_IF;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    ir_we     = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 2'b00;
    wb_sel    = 1'b0;
    alu_srcb  = 1'b0;
    ext_op    = 1'b0;
    alu_ctr   = ALU_SLT;
    ov_trap   = 1'b0;
    illegal   = 1'b0;

    case (cur_state)
      S_IF: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        pc_src    = 2'b00;
        nxt_state = S_ID;
      end

      S_ID: begin
        if (is_j) begin
          pc_we     = 1'b1;
          pc_src    = 2'b10;
          nxt_state = S_IF;
        end else if (!legal) begin
          illegal   = 1'b1;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_EXE;
        end
      end

      S_EXE: begin
        nxt_state = S_WB;
        if (is_rtype) begin
          alu_srcb = 1'b0;
          case (funct)
            FN_ADDU: alu_ctr = ALU_ADD;
            FN_SUBU: alu_ctr = ALU_SUB;
            FN_SLT:  alu_ctr = ALU_SLT;
            FN_SLL:  alu_ctr = ALU_SLL;
            default: alu_ctr = ALU_SLT;
          endcase
        end else if (is_ori) begin
          alu_ctr  = ALU_OR;
          alu_srcb = 1'b1;
          ext_op   = 1'b0;
        end else if (is_lui) begin
          alu_ctr  = ALU_LUI;
          alu_srcb = 1'b1;
        end else if (is_addi) begin
          alu_ctr  = ALU_ADD;
          alu_srcb = 1'b1;
          ext_op   = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_ctr   = ALU_ADD;
          alu_srcb  = 1'b1;
          ext_op    = 1'b1;
          nxt_state = S_MEM;
        end else if (is_beq) begin
          // Branch compares rt by subtraction; the offset is signed.
          alu_ctr   = ALU_SUB;
          alu_srcb  = 1'b0;
          ext_op    = 1'b1;
          pc_we     = zero;
          pc_src    = 2'b01;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_IF;
        end
      end

      S_MEM: begin
        if (is_sw) begin
          mem_we    = 1'b1;
          nxt_state = S_IF;
        end else if (is_lw) begin
          nxt_state = S_WB;
        end else begin
          nxt_state = S_IF;
        end
      end

      S_WB: begin
        if (is_addi && ov_reg) begin
          ov_trap = 1'b1;
        end else begin
          reg_we = 1'b1;
        end
        reg_dst   = is_rtype ? 2'b01 : 2'b00;
        wb_sel    = is_lw;
        nxt_state = S_IF;
      end

      default: begin
        nxt_state = S_IF;
      end
    endcase

    if (rst) begin
      pc_we    = 1'b0;
      pc_src   = 2'b00;
      ir_we    = 1'b0;
      mem_we   = 1'b0;
      reg_we   = 1'b0;
      reg_dst  = 2'b00;
      wb_sel   = 1'b0;
      alu_srcb = 1'b0;
      ext_op   = 1'b0;
      alu_ctr  = ALU_SLT;
      ov_trap  = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
//   Self-checking bench for mc_controller. A table of instructions (inputs
//   plus the expected per-state control values) is expanded cycle by cycle.
//   Each driven cycle pushes its expected output vector to a scoreboard
//   queue, and the vector is popped and compared on the falling edge.
//   Hand-written sequences cover reset held, reset during EXE and the
//   restart that follows it.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_we;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic       wb_sel;
  logic       alu_srcb;
  logic       ext_op;
  logic [2:0] alu_ctr;
  logic       ov_trap;
  logic       illegal;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .overflow (overflow),
    .pc_we    (pc_we),
    .pc_src   (pc_src),
    .ir_we    (ir_we),
    .mem_we   (mem_we),
    .reg_we   (reg_we),
    .reg_dst  (reg_dst),
    .wb_sel   (wb_sel),
    .alu_srcb (alu_srcb),
    .ext_op   (ext_op),
    .alu_ctr  (alu_ctr),
    .ov_trap  (ov_trap),
    .illegal  (illegal),
    .state    (state)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Output vector layout: {state, pc_we, pc_src, ir_we, mem_we, reg_we,
  // reg_dst, wb_sel, alu_srcb, ext_op, alu_ctr, ov_trap, illegal}.
  typedef logic [18:0] vec_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zf;
    logic       of;
    int         cpi;
    logic       jmp;
    logic       ill;
    logic       beq;
    logic       sw;
    logic [2:0] alu;
    logic       srcb;
    logic       ext;
    logic       trap;
    logic [1:0] rdst;
    logic       wbsel;
  } instr_t;

  instr_t tbl[15];
  vec_t   exp_q[$];
  string  name_q[$];

  function automatic instr_t mk(string name, logic [5:0] o, logic [5:0] f,
                                logic zf, logic of, int cpi, logic jmp,
                                logic ill, logic beq, logic sw, logic [2:0] alu,
                                logic srcb, logic ext, logic trap,
                                logic [1:0] rdst, logic wbsel);
    instr_t r;
    r.name = name; r.op = o; r.funct = f; r.zf = zf; r.of = of; r.cpi = cpi;
    r.jmp = jmp; r.ill = ill; r.beq = beq; r.sw = sw; r.alu = alu;
    r.srcb = srcb; r.ext = ext; r.trap = trap; r.rdst = rdst; r.wbsel = wbsel;
    return r;
  endfunction

  function automatic vec_t pack(logic [2:0] st, logic pcwe, logic [1:0] pcs,
                                logic irwe, logic memwe, logic regwe,
                                logic [1:0] rdst, logic wbs, logic srcb,
                                logic ext, logic [2:0] alu, logic ovt,
                                logic ill);
    return {st, pcwe, pcs, irwe, memwe, regwe, rdst, wbs, srcb, ext, alu, ovt, ill};
  endfunction

  // Expected outputs for cycle k of a table instruction.
  function automatic vec_t expand(instr_t r, int k);
    vec_t v;
    vec_t wb;
    wb = pack(3'd4, 1'b0, 2'b00, 1'b0, 1'b0, !r.trap, r.rdst, r.wbsel,
              1'b0, 1'b0, 3'b000, r.trap, 1'b0);
    case (k)
      0: v = pack(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0,
                  1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      1: v = pack(3'd1, r.jmp, r.jmp ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0,
                  2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, r.ill);
      2: v = pack(3'd2, r.beq & r.zf, r.beq ? 2'b01 : 2'b00, 1'b0, 1'b0,
                  1'b0, 2'b00, 1'b0, r.srcb, r.ext, r.alu, 1'b0, 1'b0);
      3: v = (r.cpi == 4 && !r.sw) ? wb :
             pack(3'd3, 1'b0, 2'b00, 1'b0, r.sw, 1'b0, 2'b00, 1'b0,
                  1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      default: v = wb;
    endcase
    return v;
  endfunction

  // Drive one cycle of an instruction. The flags carry the table value
  // only in EXE and the inverted value elsewhere, so any sampling outside
  // EXE shows up as a wrong output.
  task automatic applyStimulus(instr_t r, int k);
    op       = r.op;
    funct    = r.funct;
    zero     = (k == 2) ? r.zf : ~r.zf;
    overflow = (k == 2) ? r.of : ~r.of;
    exp_q.push_back(expand(r, k));
    name_q.push_back($sformatf("%s_c%0d", r.name, k));
  endtask

  task automatic pushExpected(string name, vec_t v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic checkOutput();
    vec_t  act;
    vec_t  want;
    string nm;
    act = {state, pc_we, pc_src, ir_we, mem_we, reg_we, reg_dst, wb_sel,
           alu_srcb, ext_op, alu_ctr, ov_trap, illegal};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty got %h want none", act);
    end else begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      if (act !== want) begin
        errors++;
        $display("[TB] FAIL %s got %h want %h", nm, act, want);
      end
    end
  endtask

  task automatic runInstr(instr_t r);
    for (int k = 0; k < r.cpi; k++) begin
      applyStimulus(r, k);
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
    end
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //              name         op         funct      zf  of  cpi j  il bq sw alu     sb ex tr rdst   wb
    tbl[0]  = mk("addu",    6'b000000, 6'b100001, 0, 0, 4, 0, 0, 0, 0, 3'b010, 0, 0, 0, 2'b01, 0);
    tbl[1]  = mk("subu",    6'b000000, 6'b100011, 1, 1, 4, 0, 0, 0, 0, 3'b110, 0, 0, 0, 2'b01, 0);
    tbl[2]  = mk("slt",     6'b000000, 6'b101010, 0, 0, 4, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2'b01, 0);
    tbl[3]  = mk("sll",     6'b000000, 6'b000000, 0, 0, 4, 0, 0, 0, 0, 3'b101, 0, 0, 0, 2'b01, 0);
    tbl[4]  = mk("ori",     6'b001101, 6'b111111, 0, 0, 4, 0, 0, 0, 0, 3'b001, 1, 0, 0, 2'b00, 0);
    tbl[5]  = mk("lui",     6'b001111, 6'b000111, 0, 0, 4, 0, 0, 0, 0, 3'b011, 1, 0, 0, 2'b00, 0);
    tbl[6]  = mk("addi_ov", 6'b001000, 6'b000000, 0, 1, 4, 0, 0, 0, 0, 3'b010, 1, 1, 1, 2'b00, 0);
    tbl[7]  = mk("addi",    6'b001000, 6'b000000, 0, 0, 4, 0, 0, 0, 0, 3'b010, 1, 1, 0, 2'b00, 0);
    tbl[8]  = mk("lw",      6'b100011, 6'b000000, 0, 0, 5, 0, 0, 0, 0, 3'b010, 1, 1, 0, 2'b00, 1);
    tbl[9]  = mk("sw",      6'b101011, 6'b000000, 0, 0, 4, 0, 0, 0, 1, 3'b010, 1, 1, 0, 2'b00, 0);
    tbl[10] = mk("beq_tk",  6'b000100, 6'b000000, 1, 0, 3, 0, 0, 1, 0, 3'b110, 0, 1, 0, 2'b00, 0);
    tbl[11] = mk("beq_nt",  6'b000100, 6'b000000, 0, 0, 3, 0, 0, 1, 0, 3'b110, 0, 1, 0, 2'b00, 0);
    tbl[12] = mk("j",       6'b000010, 6'b000000, 0, 0, 2, 1, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);
    tbl[13] = mk("ill_op",  6'b111111, 6'b000000, 0, 0, 2, 0, 1, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);
    tbl[14] = mk("ill_fn",  6'b000000, 6'b111111, 0, 0, 2, 0, 1, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);

    rst      = 1'b1;
    op       = 6'b000000;
    funct    = 6'b000000;
    zero     = 1'b0;
    overflow = 1'b0;

    // Reset held across clock edges: IF state with every output low.
    @(negedge clk);
    pushExpected("reset_hold", '0);
    checkOutput();
    @(posedge clk);
    #1;
    pushExpected("reset_hold2", '0);
    checkOutput();
    rst = 1'b0;

    // Table-driven pass over every instruction class.
    for (int i = 0; i < 15; i++) begin
      runInstr(tbl[i]);
    end

    // Reset asserted partway through the EXE cycle of an addu.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(tbl[0], k);
      @(negedge clk);
      checkOutput();
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    pushExpected("reset_async", '0);
    checkOutput();
    @(posedge clk);
    #1;
    pushExpected("reset_clocked", '0);
    checkOutput();
    rst = 1'b0;

    // The first cycle after release is a fetch, and the instruction
    // restarts cleanly from the beginning.
    runInstr(tbl[0]);
    runInstr(tbl[6]);
    runInstr(tbl[12]);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
